ack_gated_feeder: RTL and testbench
===================================

// Module: ack_gated_feeder
// PURPOSE
//  Upstream stage of the GASCore sample block.
//  - Buffers an AXI-Stream in a small FIFO.
//  - Releases one beat at a time to the downstream axis_input port.
//  - After each beat, holds the next one until the downstream ack_V rising edge.
//  - Replaces the send-one/wait-for-ack sequencing currently hand-coded in benches.
// PARAMETERS
//  DATA_WIDTH      64    tdata width
//  FIFO_DEPTH      16    buffer entries; power of 2, >= 2
//  TIMEOUT_CYCLES  1024  WAIT_ACK cycles before abort (ACK_TIMEOUT_EN only); >= 1
// PORTS
//  ap_clk              in   1            single clock
//  ap_rst_n            in   1            reset; asynchronous, active-low
//  s_axis_TDATA        in   DATA_WIDTH   upstream beat data
//  s_axis_TLAST        in   1            upstream beat last
//  s_axis_TVALID       in   1            upstream valid
//  s_axis_TREADY       out  1            !fifo_full
//  axis_input_TDATA    out  DATA_WIDTH   to sample axis_input
//  axis_input_TLAST    out  1
//  axis_input_TVALID   out  1
//  axis_input_TREADY   in   1
//  ack_V               in   1            downstream completion flag (level)
//  state_out_V         out  2            FSM state encoding
//  fifo_level          out  $clog2(FIFO_DEPTH)+1   occupied entries
//  timeout_err         out  1            1-cycle pulse on ack timeout
//  timeout_count       out  16           saturating count of timeouts
// BEHAVIOUR
//  Reset (async assert, sync deassert): all outputs 0; FIFO empty; FSM in IDLE; ack edge reg 0.
//  - s_axis_TREADY rises the first cycle after deassertion.
//  FIFO
//  - Write when s_axis_TVALID && s_axis_TREADY.
//  - Simultaneous push and pop when full is legal; level is unchanged.
//  - Pointers wrap modulo FIFO_DEPTH.
//  Ack edge: ack_rise = ack_V && !ack_q, where ack_q is ack_V registered.
//  FSM (state_out_V encoding):
//  - IDLE (0): when FIFO is non-empty, pop into the output register; next state is SEND.
//    A beat written into an empty FIFO at cycle N gives axis_input_TVALID=1 at N+2.
//  - SEND (1): TVALID held; TDATA/TLAST stable until TREADY. On handshake, TVALID=0 and next state is WAIT_ACK.
//  - WAIT_ACK (2): on ack_rise (or a pending ack), next state is IDLE. The next beat is issued no earlier than 1 cycle later.
//  Ack timing:
//  - ack_rise during IDLE or SEND before the handshake cycle: discarded.
//  - ack_rise in the handshake cycle itself: latched as ack_pend and consumed in the first WAIT_ACK cycle.
//  - ack_V held high continuously never counts twice; it must fall and rise again.
//  TLAST: passed through per beat; no effect on FSM.
//  Mid-operation reset: beat in flight is dropped; FIFO contents discarded.
// CONFIGURATION
//  ACK_TIMEOUT_EN defined:
//  - A 32-bit counter clears on WAIT_ACK entry and increments each WAIT_ACK cycle.
//  - At TIMEOUT_CYCLES: pulse timeout_err for 1 cycle, increment timeout_count (saturates at 16'hFFFF), go to IDLE.
//  - Ack on the same cycle as the timeout: ack wins; no error.
//  ACK_TIMEOUT_EN undefined:
//  - No counter logic; WAIT_ACK waits indefinitely.
//  - timeout_err and timeout_count are tied to 0; ports remain present.
// STRUCTURE
//  gascore_pkg:
//  - typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} feeder_state_t.
//  - Beat struct {tdata, tlast}.
//  - Localparam TIMEOUT_W = 32.
//  Sub-module axis_fifo_sync:
//  - Parameters: width, depth.
//  - Ports: push, pop, full, empty, level.
//  - Registered read on pop.
//  Top holds the FSM, ack edge detect, output register and the optional timeout logic.
// TESTING
//  1. Reset: hold ap_rst_n=0 40ns -> all outputs 0, state_out_V=0; s_axis_TREADY=1 on the 1st edge after release.
//  2. Push 64'hABCD then 64'h0 back-to-back, TREADY=1 ->
//     - 64'hABCD appears at N+2;
//     - 64'h0 is not issued until 1 cycle after the ack_V 0->1 pulse.
//  3. Push 17 beats with no ack ->
//     - 1 beat sent, 16 held, s_axis_TREADY=0;
//     - each ack pulse frees 1 entry and releases 1 beat, in order.
//  4. Downstream TREADY=0 for 5 cycles while in SEND -> TDATA/TLAST stable and TVALID=1 throughout; ack pulses in this window are ignored.
//  5. Ack_V held high across 3 beats -> only the first beat is acked; no further release until ack_V falls and rises.
//  6. ACK_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> timeout_err pulse 8 cycles after WAIT_ACK entry; timeout_count=1; next beat is issued.

Source files
------------

// File: rtl/gascore_pkg.sv
// Shared types for the GASCore sample-block feeder: FSM state encoding,
// buffered beat layout and timeout counter width.
package gascore_pkg;

    localparam int GAS_DATA_W = 64;
    localparam int TIMEOUT_W  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } feeder_state_t;

    typedef struct packed {
        logic [GAS_DATA_W-1:0] tdata;
        logic                  tlast;
    } beat_t;

    // Saturating increment for the 16-bit timeout event counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ack_gated_feeder_if.sv
// AXI-Stream beat channel (TDATA/TLAST/TVALID/TREADY) used on both sides
// of the feeder. master drives the beat, slave drives TREADY.
interface ack_gated_feeder_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TLAST;
    logic                  TVALID;
    logic                  TREADY;

    modport master (output TDATA, output TLAST, output TVALID, input  TREADY);
    modport slave  (input  TDATA, input  TLAST, input  TVALID, output TREADY);
endinterface

// File: rtl/axis_fifo_sync.sv
// Single-clock FIFO with a registered read port: rd_data updates on the
// edge that pops, and holds its value otherwise. Pointers wrap naturally
// because DEPTH is a power of two.
module axis_fifo_sync #(
    parameter  int WIDTH   = 65,
    parameter  int DEPTH   = 16,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LEVEL_W = PTR_W + 1
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               push,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   rd_data,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == LEVEL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop && !empty;
    // A push while full is accepted only when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);

    // Storage array write.
    // NOTE: the data array has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LEVEL_W'(1);
                2'b01:   count <= count - LEVEL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered read: the head entry is captured on the popping edge.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_data <= '0;
        end else if (do_pop) begin
            rd_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/ack_gated_feeder.sv
// ack_gated_feeder: buffers an upstream AXI-Stream and releases one beat at
// a time to axis_input, holding the next beat until ack_V rises.
// Optional ACK_TIMEOUT_EN: abandon WAIT_ACK after TIMEOUT_CYCLES cycles,
// pulsing timeout_err and bumping timeout_count. Without it both are 0.
module ack_gated_feeder
    import gascore_pkg::*;
#(
    parameter  int DATA_WIDTH     = GAS_DATA_W,
    parameter  int FIFO_DEPTH     = 16,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int LEVEL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    ack_gated_feeder_if.slave    s_axis,
    ack_gated_feeder_if.master   axis_input,
    input  logic                 ack_V,
    output logic [1:0]           state_out_V,
    output logic [LEVEL_W-1:0]   fifo_level,
    output logic                 timeout_err,
    output logic [15:0]          timeout_count
);

    feeder_state_t state;
    feeder_state_t next_state;
    beat_t         wr_beat;
    beat_t         rd_beat;
    logic          ready_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          send_valid;
    logic          ack_q;
    logic          ack_pend;
    logic          ack_rise;
    logic          ack_hit;
    logic          handshake;
    logic          timeout_hit;

    // Upstream side: ready is held low until the first edge after reset.
    assign s_axis.TREADY = ready_q && !fifo_full;
    assign push          = s_axis.TVALID && s_axis.TREADY;
    assign wr_beat       = '{tdata: s_axis.TDATA, tlast: s_axis.TLAST};

    assign ack_rise  = ack_V && !ack_q;
    assign ack_hit   = ack_rise || ack_pend;
    assign handshake = (state == SEND) && axis_input.TREADY;

    // The FIFO's registered read port doubles as the output beat register.
    axis_fifo_sync #(
        .WIDTH (($bits(beat_t))),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .push     (push),
        .wr_data  (wr_beat),
        .pop      (pop),
        .rd_data  (rd_beat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign axis_input.TDATA  = rd_beat.tdata[DATA_WIDTH-1:0];
    assign axis_input.TLAST  = rd_beat.tlast;
    assign axis_input.TVALID = send_valid;
    assign state_out_V       = state;

    // Upstream-ready enable, one cycle after reset release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) ready_q <= 1'b0;
        else           ready_q <= 1'b1;
    end

    // Ack edge detect; a rise coinciding with the handshake is kept for WAIT_ACK.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ack_q    <= 1'b0;
            ack_pend <= 1'b0;
        end else begin
            ack_q <= ack_V;
            if (handshake && ack_rise) ack_pend <= 1'b1;
            else if (state == WAIT_ACK) ack_pend <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= next_state;
    end

    // FSM next-state logic.
    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (!fifo_empty)                next_state = SEND;
            SEND:     if (axis_input.TREADY)          next_state = WAIT_ACK;
            WAIT_ACK: if (ack_hit || timeout_hit)     next_state = IDLE;
            default:                                  next_state = IDLE;
        endcase
    end

    // FSM outputs: pop in IDLE, present the beat in SEND.
    always_comb begin
        pop        = (state == IDLE) && !fifo_empty;
        send_valid = (state == SEND);
    end

`ifdef ACK_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wait_cnt;

    // An ack in the expiring cycle takes priority over the timeout.
    assign timeout_hit = (state == WAIT_ACK) && !ack_hit &&
                         (wait_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in WAIT_ACK; zero in the first WAIT_ACK cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)              wait_cnt <= '0;
        else if (state != WAIT_ACK) wait_cnt <= '0;
        else                        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
    end

    // Timeout pulse and saturating event count.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            timeout_err   <= 1'b0;
            timeout_count <= '0;
        end else begin
            timeout_err <= timeout_hit;
            if (timeout_hit) timeout_count <= sat_inc16(timeout_count);
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign timeout_err   = 1'b0;
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_ack_gated_feeder.sv
// Bench for ack_gated_feeder. Directed scenarios plus a randomized run
// checked against a beat-order queue and an ack-gating rule.
module tb_ack_gated_feeder;

    localparam int TB_DEPTH   = 16;
    localparam int TB_TIMEOUT = 8;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } tb_beat_t;

    logic        clk;
    logic        rst_n;
    logic        ack_V;
    logic [1:0]  st;
    logic [4:0]  lvl;
    logic        terr;
    logic [15:0] tcount;

    ack_gated_feeder_if #(.DATA_WIDTH(64)) s_if ();
    ack_gated_feeder_if #(.DATA_WIDTH(64)) out_if ();

    ack_gated_feeder #(
        .DATA_WIDTH     (64),
        .FIFO_DEPTH     (TB_DEPTH),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .ap_clk        (clk),
        .ap_rst_n      (rst_n),
        .s_axis        (s_if),
        .axis_input    (out_if),
        .ack_V         (ack_V),
        .state_out_V   (st),
        .fifo_level    (lvl),
        .timeout_err   (terr),
        .timeout_count (tcount)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    tb_beat_t got_q[$];
    tb_beat_t exp_q[$];

    // Gating monitor state: after each handshake, the next TVALID rise must
    // come at least two cycles after the first ack_V rise seen at or after it.
    bit ack_prev    = 0;
    bit tv_prev     = 0;
    bit have_hs     = 0;
    int first_rise  = -1;
    int gate_checks = 0;
    int gate_viol   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            have_hs = 0; first_rise = -1; ack_prev = 0; tv_prev = 0;
        end else begin
            if (out_if.TVALID && !tv_prev && have_hs) begin
                gate_checks++;
                if (first_rise < 0 || cyc < first_rise + 2) gate_viol++;
                have_hs = 0;
            end
            if (out_if.TVALID && out_if.TREADY) begin
                got_q.push_back('{d: out_if.TDATA, l: out_if.TLAST});
                have_hs = 1; first_rise = -1;
            end
            if (have_hs && ack_V && !ack_prev && first_rise < 0) first_rise = cyc;
            if (terr) have_hs = 0;
            ack_prev = ack_V;
            tv_prev  = out_if.TVALID;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d tests run", n_tests);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (st == target) begin
                ok = 1;
                break;
            end
            step(1);
        end
        if (st == target) ok = 1;
    endtask

    task automatic ack_pulse();
        ack_V = 1'b1;
        step(1);
        ack_V = 1'b0;
    endtask

    task automatic test_reset();
        #40;
        #2;
        n_tests++;
        if ({out_if.TVALID, out_if.TLAST, out_if.TDATA} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b l=%b d=%h, want all 0", out_if.TVALID, out_if.TLAST, out_if.TDATA);
        end
        n_tests++;
        if ({s_if.TREADY, st, lvl, terr, tcount} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_misc: got rdy=%b st=%0d lvl=%0d terr=%b tcnt=%0d, want all 0", s_if.TREADY, st, lvl, terr, tcount);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (s_if.TREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy_early: got %b want 0", s_if.TREADY);
        end
        step(1);
        n_tests++;
        if (s_if.TREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rdy_edge: got %b want 1", s_if.TREADY);
        end
    endtask

    task automatic test_back_to_back();
        int wait_n;
        got_q.delete();
        s_if.TVALID = 1'b1; s_if.TDATA = 64'hABCD; s_if.TLAST = 1'b0;
        step(1);
        s_if.TDATA = 64'h0; s_if.TLAST = 1'b1;
        n_tests++;
        if (out_if.TVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_n1: tvalid got %b want 0", out_if.TVALID);
        end
        step(1);
        s_if.TVALID = 1'b0;
        n_tests++;
        if ({out_if.TVALID, out_if.TDATA} !== {1'b1, 64'hABCD}) begin
            n_fail++;
            $display("FAIL b2b_n2: got v=%b d=%h want v=1 d=abcd", out_if.TVALID, out_if.TDATA);
        end
        step(1);
        n_tests++;
        if ({out_if.TVALID, st} !== {1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL b2b_wait_entry: got v=%b st=%0d want v=0 st=2", out_if.TVALID, st);
        end
        wait_n = 2 + int'($urandom_range(3));
        for (int i = 0; i < wait_n; i++) begin
            step(1);
            n_tests++;
            if (out_if.TVALID !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_hold%0d: tvalid got %b want 0", i, out_if.TVALID);
            end
        end
        ack_pulse();
        n_tests++;
        if (out_if.TVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ack_plus0: tvalid got %b want 0", out_if.TVALID);
        end
        step(1);
        n_tests++;
        if ({out_if.TVALID, out_if.TLAST, out_if.TDATA} !== {1'b1, 1'b1, 64'h0}) begin
            n_fail++;
            $display("FAIL b2b_ack_plus1: got v=%b l=%b d=%h want v=1 l=1 d=0", out_if.TVALID, out_if.TLAST, out_if.TDATA);
        end
        step(1);
        ack_pulse();
        n_tests++;
        if (got_q.size() != 2 || got_q[0] !== {64'hABCD, 1'b0} || got_q[1] !== {64'h0, 1'b1} || st !== 2'd0 || lvl !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_final: got n=%0d st=%0d lvl=%0d want n=2 in order st=0 lvl=0", got_q.size(), st, lvl);
        end
    endtask

    task automatic test_fill();
        tb_beat_t d [17];
        got_q.delete();
        for (int i = 0; i < 17; i++) begin
            d[i] = '{d: {$urandom, $urandom}, l: 1'($urandom_range(1))};
            s_if.TVALID = 1'b1; s_if.TDATA = d[i].d; s_if.TLAST = d[i].l;
            n_tests++;
            if (s_if.TREADY !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_rdy%0d: got %b want 1", i, s_if.TREADY);
            end
            step(1);
        end
        s_if.TVALID = 1'b0;
        n_tests++;
        if (lvl !== 5'd16 || s_if.TREADY !== 1'b0 || st !== 2'd2 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL fill_full: got lvl=%0d rdy=%b st=%0d sent=%0d want 16 0 2 1", lvl, s_if.TREADY, st, got_q.size());
        end
        for (int i = 1; i <= 16; i++) begin
            ack_pulse();
            step(2);
            n_tests++;
            if (lvl !== 5'(16 - i) || got_q.size() != i + 1) begin
                n_fail++;
                $display("FAIL fill_ack%0d: got lvl=%0d sent=%0d want %0d %0d", i, lvl, got_q.size(), 16 - i, i + 1);
            end
        end
        ack_pulse();
        for (int i = 0; i < 17; i++) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== d[i]) begin
                n_fail++;
                $display("FAIL fill_order%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, d[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] d;
        logic        l;
        bit          ok;
        got_q.delete();
        d = {$urandom, $urandom};
        l = 1'($urandom_range(1));
        out_if.TREADY = 1'b0;
        s_if.TVALID = 1'b1; s_if.TDATA = d; s_if.TLAST = l;
        step(1);
        s_if.TVALID = 1'b0;
        wait_state(2'd1, 5, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_send_timeout: st=%0d want 1", st);
        end
        for (int i = 0; i < 5; i++) begin
            ack_V = (i == 1 || i == 3);
            n_tests++;
            if ({out_if.TVALID, out_if.TLAST, out_if.TDATA} !== {1'b1, l, d}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", i, out_if.TVALID, out_if.TLAST, out_if.TDATA, l, d);
            end
            step(1);
        end
        ack_V = 1'b0;
        out_if.TREADY = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (st !== 2'd2) begin
                n_fail++;
                $display("FAIL stall_ack_ignored%0d: st got %0d want 2", i, st);
            end
            step(1);
        end
        ack_pulse();
        n_tests++;
        if (st !== 2'd0 || got_q.size() != 1 || got_q[0] !== {d, l}) begin
            n_fail++;
            $display("FAIL stall_final: st=%0d sent=%0d want st=0 sent=1 beat=%h", st, got_q.size(), {d, l});
        end
    endtask

    task automatic test_ack_held();
        tb_beat_t d [3];
        bit       ok;
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            d[i] = '{d: {$urandom, $urandom}, l: 1'(i == 2)};
            s_if.TVALID = 1'b1; s_if.TDATA = d[i].d; s_if.TLAST = d[i].l;
            step(1);
        end
        s_if.TVALID = 1'b0;
        wait_state(2'd2, 6, ok);
        ack_V = 1'b1;
        step(1);
        wait_state(2'd2, 6, ok);
        n_tests++;
        if (!ok || got_q.size() != 2) begin
            n_fail++;
            $display("FAIL held_second: ok=%b sent=%0d want 1 2", ok, got_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_tests++;
            if ({st, out_if.TVALID} !== {2'd2, 1'b0}) begin
                n_fail++;
                $display("FAIL held_stuck%0d: got st=%0d v=%b want st=2 v=0", i, st, out_if.TVALID);
            end
        end
        n_tests++;
        if ({terr, tcount} !== 17'd0 || got_q.size() != 2) begin
            n_fail++;
            $display("FAIL held_no_release: terr=%b tcnt=%0d sent=%0d want 0 0 2", terr, tcount, got_q.size());
        end
        ack_V = 1'b0;
        step(1);
        ack_V = 1'b1;
        step(1);
        wait_state(2'd2, 6, ok);
        n_tests++;
        if (!ok || got_q.size() != 3) begin
            n_fail++;
            $display("FAIL held_third: ok=%b sent=%0d want 1 3", ok, got_q.size());
        end
        ack_V = 1'b0;
        step(1);
        ack_pulse();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== d[i]) begin
                n_fail++;
                $display("FAIL held_order%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, d[i]);
            end
        end
    endtask

`ifdef ACK_TIMEOUT_EN
    task automatic test_timeout();
        logic [63:0] d2;
        bit          ok;
        d2 = {$urandom, $urandom};
        s_if.TVALID = 1'b1; s_if.TDATA = {$urandom, $urandom}; s_if.TLAST = 1'b0;
        step(1);
        s_if.TDATA = d2;
        step(1);
        s_if.TVALID = 1'b0;
        wait_state(2'd2, 6, ok);
        for (int i = 1; i < TB_TIMEOUT; i++) begin
            step(1);
            n_tests++;
            if ({terr, st} !== {1'b0, 2'd2}) begin
                n_fail++;
                $display("FAIL to_early%0d: got terr=%b st=%0d want 0 2", i, terr, st);
            end
        end
        step(1);
        n_tests++;
        if ({terr, tcount, st} !== {1'b1, 16'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL to_pulse: got terr=%b tcnt=%0d st=%0d want 1 1 0", terr, tcount, st);
        end
        step(1);
        n_tests++;
        if ({terr, out_if.TVALID, out_if.TDATA} !== {1'b0, 1'b1, d2}) begin
            n_fail++;
            $display("FAIL to_next: got terr=%b v=%b d=%h want 0 1 %h", terr, out_if.TVALID, out_if.TDATA, d2);
        end
        wait_state(2'd2, 6, ok);
        ack_pulse();
        n_tests++;
        if (st !== 2'd0 || tcount !== 16'd1) begin
            n_fail++;
            $display("FAIL to_final: got st=%0d tcnt=%0d want 0 1", st, tcount);
        end
    endtask
`endif

    task automatic test_random();
        int  pushed;
        int  n_beats;
        bit  ok;
        got_q.delete();
        exp_q.delete();
        pushed     = 0;
        n_beats    = 40;
        gate_viol  = 0;
        gate_checks = 0;
        for (int c = 0; c < 4000 && (pushed < n_beats || got_q.size() < n_beats); c++) begin
            s_if.TVALID = (pushed < n_beats) && ($urandom_range(1) == 1);
            s_if.TDATA  = {$urandom, $urandom};
            s_if.TLAST  = 1'($urandom_range(1));
            if (s_if.TVALID && s_if.TREADY) begin
                exp_q.push_back('{d: s_if.TDATA, l: s_if.TLAST});
                pushed++;
            end
            out_if.TREADY = ($urandom_range(3) != 0);
            ack_V         = ($urandom_range(2) == 0);
            step(1);
        end
        s_if.TVALID   = 1'b0;
        out_if.TREADY = 1'b1;
        ack_V         = 1'b0;
        step(1);
        ack_pulse();
        wait_state(2'd0, 10, ok);
        n_tests++;
        if (got_q.size() != n_beats || exp_q.size() != n_beats) begin
            n_fail++;
            $display("FAIL rand_count: got %0d delivered, %0d pushed, want %0d", got_q.size(), exp_q.size(), n_beats);
        end
        for (int i = 0; i < n_beats && i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (gate_viol != 0 || gate_checks == 0) begin
            n_fail++;
            $display("FAIL rand_gating: got %0d violations in %0d releases, want 0 in >0", gate_viol, gate_checks);
        end
        n_tests++;
        if ({st, lvl} !== 7'd0) begin
            n_fail++;
            $display("FAIL rand_drain: got st=%0d lvl=%0d want 0 0", st, lvl);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        for (int i = 0; i < 3; i++) begin
            s_if.TVALID = 1'b1; s_if.TDATA = {$urandom, $urandom}; s_if.TLAST = 1'b1;
            step(1);
        end
        s_if.TVALID = 1'b0;
        wait_state(2'd1, 6, ok);
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({out_if.TVALID, out_if.TLAST, out_if.TDATA, st, lvl, s_if.TREADY} !== 73'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: got v=%b d=%h st=%0d lvl=%0d rdy=%b want all 0", out_if.TVALID, out_if.TDATA, st, lvl, s_if.TREADY);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_tests++;
            if ({out_if.TVALID, lvl, s_if.TREADY} !== {1'b0, 5'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL midrst_after%0d: got v=%b lvl=%0d rdy=%b want 0 0 1", i, out_if.TVALID, lvl, s_if.TREADY);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        ack_V         = 1'b0;
        s_if.TVALID   = 1'b0;
        s_if.TDATA    = '0;
        s_if.TLAST    = 1'b0;
        out_if.TREADY = 1'b1;
        test_reset();
        test_back_to_back();
`ifndef ACK_TIMEOUT_EN
        test_fill();
`endif
        test_stall();
        test_ack_held();
`ifdef ACK_TIMEOUT_EN
        test_timeout();
`else
        test_random();
`endif
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
